// File: rtl/instruction_fetch_if.sv
// Instruction-memory port of the fetch stage.
// Handshake: the fetch side holds imemReq high with a stable imemAddr for every
// cycle it waits for a word; the memory answers by raising imemAck for exactly the
// cycle in which imemData carries that word. A cycle with imemReq low has no
// transaction, so any imemAck seen then is meaningless and is discarded.
interface instruction_fetch_if;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck;
    logic [31:0] imemData;

    modport master (output imemReq, output imemAddr, input imemAck, input imemData);
    modport slave  (input imemReq, input imemAddr, output imemAck, output imemData);
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, fetches one word per instruction over the imem
// handshake, holds it for decode until advance, then picks the next PC
// (jump > branch > sequential). Memory timeouts and misaligned branch targets
// park the block in a sticky fault state that only reset clears.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       advance,
    input  logic                       branchTaken,
    input  logic [31:0]                branchTarget,
    input  logic                       jump,
    input  logic [25:0]                jumpTarget,
    instruction_fetch_if.master        imem,
    output logic [31:0]                instruction,
    output logic [31:0]                pc,
    output logic [31:0]                pcPlus4,
    output logic                       instrValid,
    output logic                       fetchFault,
    output logic [1:0]                 o_dbg_state
);

    typedef enum logic [1:0] {
        S_START = 2'd0,
        S_FETCH = 2'd1,
        S_VALID = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    // Counter value on the last FETCH cycle allowed before declaring a timeout.
    localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic [31:0] r_instr, w_instr_nxt;
    logic [7:0]  r_cnt, w_cnt_nxt;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_jump_pc;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_jump_pc  = {w_pc_plus4[31:28], jumpTarget, 2'b00};

    // State, PC, held instruction and timeout counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_START;
            r_pc    <= RESET_PC;
            r_instr <= 32'h0;
            r_cnt   <= 8'h0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_instr <= w_instr_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic: capture on ack, time out without one, select next PC on advance.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_instr_nxt = r_instr;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_START: w_state_nxt = S_FETCH;
            S_FETCH: begin
                if (imem.imemAck) begin
                    w_instr_nxt = imem.imemData;
                    w_cnt_nxt   = 8'h0;
                    w_state_nxt = S_VALID;
                end else if (r_cnt == LP_CNT_LAST) begin
                    w_state_nxt = S_FAULT;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            S_VALID: begin
                if (advance) begin
                    if (jump) begin
                        w_pc_nxt    = w_jump_pc;
                        w_state_nxt = S_FETCH;
                    end else if (branchTaken) begin
                        // A misaligned target is never loaded; the PC keeps pointing at the
                        // offending branch so the fault can be traced.
                        if (branchTarget[1:0] != 2'b00) begin
                            w_state_nxt = S_FAULT;
                        end else begin
                            w_pc_nxt    = branchTarget;
                            w_state_nxt = S_FETCH;
                        end
                    end else begin
                        w_pc_nxt    = w_pc_plus4;
                        w_state_nxt = S_FETCH;
                    end
                end
            end
            S_FAULT: w_state_nxt = S_FAULT;
            default: w_state_nxt = S_START;
        endcase
    end

    // Outputs decode straight from the state register so reset clears them at once.
    assign imem.imemReq  = (r_state == S_FETCH);
    assign imem.imemAddr = r_pc;
    assign instruction   = r_instr;
    assign pc            = r_pc;
    assign pcPlus4       = w_pc_plus4;
    assign instrValid    = (r_state == S_VALID);
    assign fetchFault    = (r_state == S_FAULT);
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: reset, sequential fetch, jump priority,
// misaligned branch fault, memory timeout, and PC wrap with a second instance.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        advance, branchTaken, jump;
    logic [31:0] branchTarget;
    logic [25:0] jumpTarget;
    logic [31:0] instruction, pc, pcPlus4;
    logic        instrValid, fetchFault;
    logic [1:0]  dbg_state;

    logic        reset2, advance2;
    logic [31:0] instruction2, pc2, pcPlus4_2;
    logic        instrValid2, fetchFault2;
    logic [1:0]  dbg_state2;
    logic        zero1;
    logic [31:0] zero32;
    logic [25:0] zero26;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    instruction_fetch_if m_if ();
    instruction_fetch_if m2_if ();

    instruction_fetch dut (
        .clk(clk), .reset(reset), .advance(advance), .branchTaken(branchTaken),
        .branchTarget(branchTarget), .jump(jump), .jumpTarget(jumpTarget),
        .imem(m_if.master), .instruction(instruction), .pc(pc), .pcPlus4(pcPlus4),
        .instrValid(instrValid), .fetchFault(fetchFault), .o_dbg_state(dbg_state)
    );

    instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .reset(reset2), .advance(advance2), .branchTaken(zero1),
        .branchTarget(zero32), .jump(zero1), .jumpTarget(zero26),
        .imem(m2_if.master), .instruction(instruction2), .pc(pc2), .pcPlus4(pcPlus4_2),
        .instrValid(instrValid2), .fetchFault(fetchFault2), .o_dbg_state(dbg_state2)
    );

    // Clock and global time bound.
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word for a single cycle; it is captured at the next edge.
    task automatic ack_now(input logic [31:0] data);
        m_if.imemAck  = 1'b1;
        m_if.imemData = data;
        tick();
        m_if.imemAck  = 1'b0;
        m_if.imemData = 32'hDEAD_BEEF;
    endtask

    initial begin
        logic [31:0] e;
        reset = 1'b0; reset2 = 1'b0;
        advance = 1'b0; branchTaken = 1'b0; jump = 1'b0;
        branchTarget = 32'h0; jumpTarget = 26'h0;
        advance2 = 1'b0; zero1 = 1'b0; zero32 = 32'h0; zero26 = 26'h0;
        m_if.imemAck = 1'b0; m_if.imemData = 32'hDEAD_BEEF;
        m2_if.imemAck = 1'b0; m2_if.imemData = 32'h0;
        tick(); tick();

        // Reset state
        chk("rst_req", m_if.imemReq, 0);
        chk("rst_valid", instrValid, 0);
        chk("rst_fault", fetchFault, 0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instruction, 32'h0);
        chk("rst_pc2", pc2, 32'hFFFF_FFFC);

        // Test 1: ack on third FETCH cycle
        reset = 1'b1;
        chk("t1_start_req", m_if.imemReq, 0);
        chk("t1_start_state", dbg_state, 0);
        tick();
        chk("t1_c1_req", m_if.imemReq, 1);
        chk("t1_c1_addr", m_if.imemAddr, 32'h0);
        tick();
        chk("t1_c2_valid", instrValid, 0);
        chk("t1_c2_addr", m_if.imemAddr, 32'h0);
        ack_now(32'h2008_0005);
        chk("t1_instr", instruction, 32'h2008_0005);
        chk("t1_valid", instrValid, 1);
        chk("t1_pc", pc, 32'h0);
        chk("t1_pcp4", pcPlus4, 32'h4);
        chk("t1_req_low", m_if.imemReq, 0);

        // Test 2: sequential advances; advance/jump during FETCH ignored
        for (int i = 0; i < 3; i++) exp_q.push_back(32'(4 * (i + 1)));
        for (int i = 0; i < 3; i++) begin
            advance = 1'b1; tick(); advance = 1'b0;
            e = exp_q.pop_front();
            chk("t2_valid_drop", instrValid, 0);
            chk("t2_addr", m_if.imemAddr, e);
            advance = 1'b1; jump = 1'b1; jumpTarget = 26'h3FF_FFFF;
            tick();
            advance = 1'b0; jump = 1'b0;
            chk("t2_ign_addr", m_if.imemAddr, e);
            chk("t2_ign_valid", instrValid, 0);
            ack_now(32'h0000_1000 + 32'(i));
            chk("t2_pc", pc, e);
            chk("t2_instr", instruction, 32'h0000_1000 + 32'(i));
        end

        // Test 3: aligned branch, then jump beats a (misaligned) branch
        advance = 1'b1; branchTaken = 1'b1; branchTarget = 32'h1000_0010;
        tick();
        advance = 1'b0; branchTaken = 1'b0;
        chk("t3_br_addr", m_if.imemAddr, 32'h1000_0010);
        tick();
        ack_now(32'h0800_0040);
        chk("t3_br_pc", pc, 32'h1000_0010);
        advance = 1'b1; jump = 1'b1; jumpTarget = 26'h000_0040;
        branchTaken = 1'b1; branchTarget = 32'h0000_0022;
        tick();
        advance = 1'b0; jump = 1'b0; branchTaken = 1'b0;
        chk("t3_jmp_addr", m_if.imemAddr, 32'h1000_0100);
        chk("t3_jmp_nofault", fetchFault, 0);
        ack_now(32'h1234_5678);

        // Test 4: misaligned branch faults and sticks
        advance = 1'b1; branchTaken = 1'b1; branchTarget = 32'h0000_0022;
        tick();
        advance = 1'b0; branchTaken = 1'b0;
        chk("t4_fault", fetchFault, 1);
        chk("t4_pc", pc, 32'h1000_0100);
        chk("t4_req", m_if.imemReq, 0);
        chk("t4_valid", instrValid, 0);
        m_if.imemAck = 1'b1; m_if.imemData = 32'hFFFF_FFFF; advance = 1'b1;
        repeat (3) tick();
        m_if.imemAck = 1'b0; advance = 1'b0;
        chk("t4_sticky", fetchFault, 1);
        chk("t4_pc_hold", pc, 32'h1000_0100);
        chk("t4_instr_hold", instruction, 32'h1234_5678);
        chk("t4_req_hold", m_if.imemReq, 0);

        // Test 5: async reset clears the fault, ack in START ignored, timeout
        reset = 1'b0;
        #1;
        chk("t5_rst_fault", fetchFault, 0);
        chk("t5_rst_pc", pc, 32'h0);
        tick();
        m_if.imemAck = 1'b1; m_if.imemData = 32'hAAAA_AAAA;
        reset = 1'b1;
        chk("t5_start_req", m_if.imemReq, 0);
        tick();
        m_if.imemAck = 1'b0;
        chk("t5_start_ack_ign", instrValid, 0);
        chk("t5_c1_req", m_if.imemReq, 1);
        repeat (15) tick();
        chk("t5_c16_nofault", fetchFault, 0);
        chk("t5_c16_req", m_if.imemReq, 1);
        tick();
        chk("t5_c17_fault", fetchFault, 1);
        chk("t5_c17_req", m_if.imemReq, 0);
        reset = 1'b0; tick(); reset = 1'b1;
        tick();
        repeat (14) tick();
        chk("t5_c15_req", m_if.imemReq, 1);
        ack_now(32'h5555_0001);
        chk("t5_late_valid", instrValid, 1);
        chk("t5_late_nofault", fetchFault, 0);
        chk("t5_late_instr", instruction, 32'h5555_0001);

        // Test 6: PC wrap from 0xFFFF_FFFC and async reset mid-FETCH
        reset2 = 1'b1;
        tick();
        chk("t6_addr", m2_if.imemAddr, 32'hFFFF_FFFC);
        chk("t6_pcp4", pcPlus4_2, 32'h0);
        m2_if.imemAck = 1'b1; m2_if.imemData = 32'h0000_0020;
        tick();
        m2_if.imemAck = 1'b0;
        chk("t6_valid", instrValid2, 1);
        chk("t6_instr", instruction2, 32'h0000_0020);
        advance2 = 1'b1; tick(); advance2 = 1'b0;
        chk("t6_wrap_pc", pc2, 32'h0);
        chk("t6_wrap_addr", m2_if.imemAddr, 32'h0);
        chk("t6_nofault", fetchFault2, 0);
        chk("t6_req", m2_if.imemReq, 1);
        #2;
        reset2 = 1'b0;
        #1;
        chk("t6_async_req", m2_if.imemReq, 0);
        chk("t6_async_pc", pc2, 32'hFFFF_FFFC);
        chk("t6_async_state", dbg_state2, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage directly upstream of instruction decode in the single-cycle-per-instruction MIPS core.
- Owns the PC and requests one 32-bit word per instruction over a req/ack instruction-memory handshake.
- Holds the fetched word stable for decode/control until the core signals `advance`, then selects the next PC: sequential, branch, or jump.
- Detects memory timeout and misaligned branch targets and raises a sticky fault.

Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `TIMEOUT_CYCLES`, default 16: maximum cycles in FETCH without `imemAck` before fault. Legal range is 2..255.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `advance` in 1: current instruction retired; load the next PC and fetch.
- `branchTaken` in 1: use `branchTarget` on `advance`.
- `branchTarget` in 32: absolute branch address.
- `jump` in 1: use the jump target on `advance`.
- `jumpTarget` in 26: instr[25:0] field of the current jump.
- `imemReq` out 1: memory request.
- `imemAddr` out 32: word address (byte-addressed, [1:0]=00).
- `imemAck` in 1: memory data valid this cycle.
- `imemData` in 32: instruction word.
- `instruction` out 32: held instruction to decode (decode consumes [25:0]; control consumes [31:26]).
- `pc` out 32: address of the held instruction.
- `pcPlus4` out 32: `pc`+4, used by link and branch adders.
- `instrValid` out 1: `instruction` is valid.
- `fetchFault` out 1: sticky fault flag.

Behaviour:
- States are START, FETCH, VALID and FAULT. Reset (`reset`=0, async) forces:
  - state=START, `pc`=`RESET_PC`, `instruction`=0, timeout counter=0;
  - outputs `imemReq`=0, `instrValid`=0, `fetchFault`=0.
- START:
  - `imemReq`=0.
  - Goes to FETCH on the first clock edge after reset release.
- FETCH:
  - `imemReq`=1 and `imemAddr`=`pc`, both driven combinationally from state.
  - On a cycle with `imemAck`=1: `instruction`<=`imemData`, counter<=0, state<=VALID. `instrValid` rises on the following cycle (1-cycle latency from ack).
  - Ack already high on the first FETCH cycle is legal; the minimum fetch is 2 cycles.
  - Without ack: counter increments. If counter==`TIMEOUT_CYCLES`-1 and still no ack, go to FAULT.
  - `advance`, `branchTaken` and `jump` are ignored in FETCH.
- VALID:
  - `instrValid`=1, `imemReq`=0; `instruction` and `pc` are held.
  - `imemAck` in any non-FETCH state is ignored, and `imemData` is not sampled.
  - On `advance`=1, next `pc` is chosen by priority:
    - jump: {`pcPlus4`[31:28], `jumpTarget`, 2'b00};
    - else `branchTaken`: `branchTarget`;
    - else `pcPlus4`.
  - Then state<=FETCH and `instrValid` drops the next cycle.
  - If `jump` and `branchTaken` are both 1, jump wins.
  - If the selected target is `branchTarget` and `branchTarget`[1:0]!=0: go to FAULT and leave `pc` unchanged.
- FAULT:
  - `fetchFault`=1, `imemReq`=0, `instrValid`=0.
  - All inputs are ignored; only reset exits.
- Arithmetic:
  - `pcPlus4`=`pc`+4 modulo 2^32, so 32'hFFFF_FFFC wraps to 0 with no fault.
  - `imemAddr` always equals `pc`.
- Reset mid-operation:
  - Async reset during FETCH drops `imemReq` immediately (same cycle, no clock needed).
  - A late ack after reset release, while the block is in START, is ignored.

Test Plan:
1. Reset release, memory acks on 3rd FETCH cycle with 32'h2008_0005 -> `imemAddr`=0 while waiting; `instruction`=32'h2008_0005, `instrValid`=1, `pc`=0, `pcPlus4`=4 one cycle after ack.
2. Three `advance` pulses with no branch or jump -> fetch addresses 4, 8, 12. `instrValid` is low for at least 2 cycles between instructions, and `advance` during FETCH has no effect.
3. `pc`=32'h1000_0010, `advance` with `jump`=1, `jumpTarget`=26'h000_0040 and `branchTaken`=1 -> next `imemAddr`=32'h1000_0100 (jump priority).
4. `advance` with `branchTaken`=1, `branchTarget`=32'h0000_0022 -> `fetchFault`=1, `pc` unchanged, `imemReq`=0 thereafter. Later acks and `advance` pulses are ignored until reset.
5. No ack for 16 cycles in FETCH -> `fetchFault`=1 on cycle 17. Ack arriving on cycle 15 instead -> no fault, `instrValid`=1.
6. `RESET_PC`=32'hFFFF_FFFC, ack, `advance` -> next `pc`=0, no fault. Assert `reset`=0 mid-FETCH -> `imemReq`=0 asynchronously and `pc`=32'hFFFF_FFFC.
